iir_filter_bank: RTL and testbench
==================================

IIR_FILTER_BANK -- requirements
Module: iir_filter_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 20, sample and output width in bits (two's complement).
REQ-002 SHALL have parameter CH, default 4, channel count (1..16).
REQ-003 SHALL have parameter KW, default 4, width of shift control k; KMAX = 2**KW-1.
REQ-004 qzt_clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 clk_in  input  1  sample strobe; each rising edge, detected in qzt_clk domain, starts one filter update.
REQ-007 k  input  KW  filter shift; pole = 1-2^-k; k=0 is pass-through.
REQ-008 mode  input  1  0 = low-pass output, 1 = high-pass output (x - low-pass).
REQ-009 clr  input  1  synchronous clear of all channel states and outputs.
REQ-010 vin  input  CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-011 vout  output  CH*WIDTH  registered filter outputs, same packing.
REQ-012 busy  output  1  high while an update is in progress.
REQ-013 done  output  1  one-cycle pulse when vout is updated.
REQ-014 overrun  output  1  one-cycle pulse when a strobe edge is dropped.

Function
REQ-015 Edge detect SHALL register clk_in to clk_in_old; edge = clk_in & ~clk_in_old.
REQ-016 FSM SHALL have states IDLE, CALC, DONE.
REQ-017 IDLE + edge (cycle T): SHALL snapshot vin, k and mode, clear the channel index to 0, and go to CALC.
REQ-018 CALC SHALL process one channel per cycle, index 0..CH-1, using one shared arithmetic datapath, cycles T+1..T+CH; after index CH-1 SHALL go to DONE.
REQ-019 DONE (cycle T+CH+1): SHALL load all CH results into vout simultaneously, pulse done, and return to IDLE.
REQ-020 busy SHALL be high in CALC and DONE, low in IDLE.
REQ-021 Per channel, state s SHALL be WIDTH+KMAX bits signed, holding y scaled by 2^KMAX.
REQ-022 Update SHALL be s <= s + ((x<<<KMAX) - s) >>> k, with x sign-extended, the difference computed at WIDTH+KMAX+1 bits, and arithmetic shift (floor).
REQ-023 Low-pass value lp SHALL be s_new >>> KMAX (floor), always within WIDTH range.
REQ-024 mode=0: vout_i = lp; mode=1: vout_i = x - lp computed at WIDTH+1 bits, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-025 State SHALL update in both modes; a mode change takes effect on the next strobe without a state reset.
REQ-026 k=0 SHALL give lp = x exactly; values of k above KMAX cannot occur by construction.
REQ-027 An edge while busy SHALL be dropped, pulse overrun in that cycle, and leave the in-flight update unaffected.
REQ-028 clr SHALL zero all s and vout next cycle, abort any update, and return to IDLE with done not pulsed.
REQ-029 clr and edge in the same cycle: clr SHALL win, edge SHALL be dropped, and overrun SHALL NOT pulse.
REQ-030 vin, k and mode changes after the snapshot SHALL NOT affect the in-flight update.

Reset
REQ-031 While reset is high: s, vout = 0; busy, done, overrun = 0; FSM = IDLE; index = 0; snapshots = 0.
REQ-032 clk_in_old SHALL reset to 1 so that clk_in held high through reset release produces no edge.
REQ-033 Reset asserted mid-CALC SHALL abort immediately, and no partial vout update SHALL occur.

Verification (WIDTH=20, CH=4, KW=4)
REQ-034 k=0, mode=0, ch0=1000, one strobe at T -> vout ch0=1000, done at T+5, busy high T+1..T+5.
REQ-035 k=1, mode=0, zero state, ch0=+1000, ch1=-1000, five strobes -> ch0 500,750,875,937,968; ch1 -500,-750,-875,-938,-969.
REQ-036 Settle ch2 at 524287 (k=0), then k=15, mode=1, x=-524288, one strobe -> lp=524255, vout ch2=-524288 (saturated).
REQ-037 Strobe at T, second edge at T+2 -> overrun pulse at T+2, single done at T+5, vout from the first snapshot only.
REQ-038 reset asserted at T+2 of an update, clk_in held high through release -> all outputs 0 immediately, no done, no update until the next genuine rising edge.
REQ-039 clr with a simultaneous edge after REQ-035 -> all vout=0 next cycle, no done, no overrun; next strobe restarts from zero state.

Source files
------------

// File: rtl/iir_filter_bank.sv
// Multi-channel first-order IIR bank: one shared datapath walks the channels
// after each sample strobe, then publishes all results to vout together.
module iir_filter_bank #(
    parameter int WIDTH = 20,
    parameter int CH    = 4,
    parameter int KW    = 4
) (
    input  logic                  qzt_clk,
    input  logic                  reset,
    input  logic                  clk_in,
    input  logic [KW-1:0]         k,
    input  logic                  mode,
    input  logic                  clr,
    input  logic [CH*WIDTH-1:0]   vin,
    output logic [CH*WIDTH-1:0]   vout,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);
    localparam int KMAX = 2**KW - 1;
    localparam int SW   = WIDTH + KMAX;
    localparam int DW   = SW + 1;
    localparam int IW   = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   clk_in_old_q;
    logic [IW-1:0]          idx_q, idx_d;
    logic [KW-1:0]          k_q;
    logic                   mode_q;
    logic [CH*WIDTH-1:0]    vin_q;
    logic signed [SW-1:0]   s_q [CH];
    logic [CH-1:0][WIDTH-1:0] res_q;
    logic [CH*WIDTH-1:0]    vout_q, vout_ld;

    logic                   edge_det, last;
    logic signed [WIDTH-1:0] x, lp, y;
    logic signed [SW-1:0]   s_cur, s_new;
    logic signed [DW-1:0]   xs, diff, step, sum;
    logic signed [WIDTH:0]  hp;

    assign edge_det = clk_in & ~clk_in_old_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign overrun  = edge_det & busy & ~clr;
    assign vout     = vout_q;
    assign last     = (idx_q == IW'(CH-1));

    // Shared datapath: state holds y scaled by 2^KMAX so small k steps keep precision.
    always_comb begin
        x     = $signed(vin_q[idx_q*WIDTH +: WIDTH]);
        s_cur = s_q[idx_q];
        xs    = $signed({{(KMAX+1){x[WIDTH-1]}}, x}) <<< KMAX;
        diff  = xs - $signed({s_cur[SW-1], s_cur});
        step  = diff >>> k_q;
        sum   = $signed({s_cur[SW-1], s_cur}) + step;
        s_new = sum[SW-1:0];
        lp    = s_new[SW-1:KMAX];
        hp    = $signed({x[WIDTH-1], x}) - $signed({lp[WIDTH-1], lp});
        if (hp[WIDTH] != hp[WIDTH-1])
            y = hp[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            y = hp[WIDTH-1:0];
        if (!mode_q)
            y = lp;
    end

    always_comb begin
        vout_ld = '0;
        for (int i = 0; i < CH; i++)
            vout_ld[i*WIDTH +: WIDTH] = (IW'(i) == idx_q) ? y : res_q[i];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (edge_det) begin state_d = CALC; idx_d = '0; end
            CALC: begin
                idx_d = idx_q + 1'b1;
                if (last) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d = IDLE;
            idx_d   = '0;
        end
    end

    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            clk_in_old_q <= 1'b1;
            idx_q        <= '0;
            k_q          <= '0;
            mode_q       <= 1'b0;
            vin_q        <= '0;
            res_q        <= '0;
            vout_q       <= '0;
            for (int i = 0; i < CH; i++) s_q[i] <= '0;
        end else begin
            clk_in_old_q <= clk_in;
            state_q      <= state_d;
            idx_q        <= idx_d;
            if (clr) begin
                vout_q <= '0;
                for (int i = 0; i < CH; i++) s_q[i] <= '0;
            end else if (state_q == IDLE && edge_det) begin
                vin_q  <= vin;
                k_q    <= k;
                mode_q <= mode;
            end else if (state_q == CALC) begin
                s_q[idx_q]   <= s_new;
                res_q[idx_q] <= y;
                // vout and done appear together in the DONE cycle
                if (last) vout_q <= vout_ld;
            end
        end
    end
endmodule

// File: tb/tb_iir_filter_bank.sv
// Directed bench for iir_filter_bank with hand-computed expected outputs.
module tb_iir_filter_bank;
    localparam int W = 20, CH = 4, KW = 4;

    logic            qzt_clk = 0, reset = 1, clk_in = 0, mode = 0, clr = 0;
    logic [KW-1:0]   k = 0;
    logic [CH*W-1:0] vin = '0;
    logic [CH*W-1:0] vout;
    logic            busy, done, overrun;

    int n_chk = 0, n_err = 0;

    iir_filter_bank #(.WIDTH(W), .CH(CH), .KW(KW)) dut (
        .qzt_clk(qzt_clk), .reset(reset), .clk_in(clk_in), .k(k), .mode(mode),
        .clr(clr), .vin(vin), .vout(vout), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 qzt_clk = ~qzt_clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint vch(input int i);
        logic signed [W-1:0] v;
        v = vout[i*W +: W];
        return longint'(v);
    endfunction

    task automatic set_ch(input int i, input int val);
        logic [W-1:0] v;
        v = val[W-1:0];
        vin[i*W +: W] = v;
    endtask

    task automatic tick();
        @(posedge qzt_clk); #1;
    endtask

    // Raise clk_in in cycle T; return the cycle offset at which done is seen.
    task automatic strobe(output int lat);
        lat = -1;
        clk_in = 1;
        tick();
        clk_in = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge qzt_clk);
            if (done) begin lat = c; break; end
            tick();
        end
        tick();
    endtask

    int lat, ndone, dcyc, seen;
    int exp0 [5] = '{500, 750, 875, 937, 968};
    int exp1 [5] = '{-500, -750, -875, -938, -969};

    initial begin
        // reset state
        #12;
        @(negedge qzt_clk);
        chk("rst_vout", longint'(vout == '0), 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovr", overrun, 0);
        tick(); reset = 0; tick();

        // k=0 pass-through with cycle-by-cycle busy/done
        k = 0; mode = 0; set_ch(0, 1000);
        clk_in = 1;
        @(negedge qzt_clk);
        chk("p_busyT", busy, 0);
        tick(); clk_in = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge qzt_clk);
            chk($sformatf("p_busy%0d", c), busy, 1);
            chk($sformatf("p_done%0d", c), done, (c == 5) ? 1 : 0);
            if (c == 5) chk("p_ch0", vch(0), 1000);
            tick();
        end
        @(negedge qzt_clk);
        chk("p_busy6", busy, 0);
        chk("p_done6", done, 0);
        tick();

        // plain clear
        clr = 1; tick(); clr = 0;
        @(negedge qzt_clk);
        chk("clr_vout", longint'(vout == '0), 1);
        tick();

        // k=1 step responses
        k = 1; set_ch(0, 1000); set_ch(1, -1000);
        for (int n = 0; n < 5; n++) begin
            strobe(lat);
            chk($sformatf("k1_lat%0d", n), lat, 5);
            chk($sformatf("k1_ch0_%0d", n), vch(0), exp0[n]);
            chk($sformatf("k1_ch1_%0d", n), vch(1), exp1[n]);
        end

        // clr with simultaneous edge
        clr = 1; clk_in = 1;
        @(negedge qzt_clk);
        chk("ce_ovr", overrun, 0);
        tick(); clr = 0;
        @(negedge qzt_clk);
        chk("ce_vout", longint'(vout == '0), 1);
        chk("ce_busy", busy, 0);
        chk("ce_done", done, 0);
        tick(); clk_in = 0; tick();
        strobe(lat);
        chk("ce_lat", lat, 5);
        chk("ce_ch0", vch(0), 500);
        chk("ce_ch1", vch(1), -500);

        // high-pass saturation on ch2
        k = 0; mode = 0; set_ch(2, 524287);
        strobe(lat);
        chk("sat_settle", vch(2), 524287);
        k = 15; mode = 1; set_ch(2, -524288);
        strobe(lat);
        chk("sat_ch2", vch(2), -524288);
        chk("sat_ch0_hp", vch(0), 0);
        k = 0; mode = 0;
        strobe(lat);
        chk("sat_lp_back", vch(2), -524288);

        // overrun: second edge at T+2
        k = 0; mode = 0; set_ch(3, 123);
        clk_in = 1;
        tick(); clk_in = 0;
        @(negedge qzt_clk);
        chk("ov_T1", overrun, 0);
        tick();
        set_ch(3, 456); k = 1; clk_in = 1;
        @(negedge qzt_clk);
        chk("ov_T2", overrun, 1);
        tick(); clk_in = 0;
        ndone = 0; dcyc = -1;
        for (int c = 3; c <= 8; c++) begin
            @(negedge qzt_clk);
            if (done) begin ndone++; dcyc = c; end
            tick();
        end
        chk("ov_ndone", ndone, 1);
        chk("ov_dcyc", dcyc, 5);
        chk("ov_ch3", vch(3), 123);

        // reset mid-update with clk_in held high through release
        k = 0; set_ch(1, 777);
        clk_in = 1;
        tick(); tick();
        reset = 1;
        @(negedge qzt_clk);
        chk("mr_vout", longint'(vout == '0), 1);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        tick(); tick();
        reset = 0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge qzt_clk);
            if (busy || done) seen++;
            tick();
        end
        chk("mr_quiet", seen, 0);
        chk("mr_vout2", longint'(vout == '0), 1);
        clk_in = 0; tick();
        strobe(lat);
        chk("mr_lat", lat, 5);
        chk("mr_ch1", vch(1), 777);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
